// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute sequencer for the 16-bit CPU datapath.
// Latches one instruction word into ir on FETCH and steps the 4-bit control
// state through the per-opcode execution sequence, flagging the final cycle
// (done), the TRAP cycle (illegal) and counting retired instructions.
//
// Optional feature macro: SEQ_SINGLE_STEP_EN adds a `step` input; FETCH and all
// execution states then advance only on edges where step=1. IDLE->FETCH still
// needs only run. Without the macro the block advances every cycle.
//
// Handshake: run is a level request sampled only while the sequencer is in
// IDLE (busy=0); while busy=1 run is ignored and never queued. din has no
// valid/ready of its own: it must be valid during the FETCH cycle and is
// captured at the edge that ends it.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [15:0]      din,
  output logic [15:0]      ir,
  output logic [3:0]       state,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic             step
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_FETCH  = 4'b0001,
    S_LOAD   = 4'b0010,
    S_MOVE   = 4'b0011,
    S_LDPC   = 4'b0100,
    S_BRANCH = 4'b0101,
    S_SUB0   = 4'b0110,
    S_SUB1   = 4'b0111,
    S_SUB2   = 4'b1000,
    S_ADD0   = 4'b1001,
    S_ADD1   = 4'b1010,
    S_ADD2   = 4'b1011,
    S_XOR0   = 4'b1100,
    S_XOR1   = 4'b1101,
    S_XOR2   = 4'b1110,
    S_TRAP   = 4'b1111
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic             adv;

`ifdef SEQ_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // Next-state, instruction latch and retire counter.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (adv) begin
          ir_d = din;
          case (din[15:13])
            3'b000:  state_d = S_LOAD;
            3'b001:  state_d = S_MOVE;
            3'b010:  state_d = S_LDPC;
            3'b011:  state_d = S_BRANCH;
            3'b100:  state_d = S_SUB0;
            3'b101:  state_d = S_ADD0;
            3'b110:  state_d = S_XOR0;
            default: state_d = S_TRAP;
          endcase
        end
      end
      S_LOAD, S_MOVE, S_LDPC, S_BRANCH, S_TRAP,
      S_SUB2, S_ADD2, S_XOR2: begin
        if (adv) state_d = S_IDLE;
      end
      S_SUB0: if (adv) state_d = S_SUB1;
      S_SUB1: if (adv) state_d = S_SUB2;
      S_ADD0: if (adv) state_d = S_ADD1;
      S_ADD1: if (adv) state_d = S_ADD2;
      S_XOR0: if (adv) state_d = S_XOR1;
      S_XOR1: if (adv) state_d = S_XOR2;
      default: state_d = S_IDLE;
    endcase
    // done_q mirrors the current state, so this counts exits from final states.
    if (adv && done_q) cnt_d = cnt_q + CNT_ONE;
  end

  // Flag outputs precomputed from the next state so they register alongside it.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    illegal_d = (state_d == S_TRAP);
    case (state_d)
      S_LOAD, S_MOVE, S_LDPC, S_BRANCH, S_TRAP,
      S_SUB2, S_ADD2, S_XOR2: done_d = 1'b1;
      default:                done_d = 1'b0;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      ir_q      <= 16'h0000;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign state       = state_q;
  assign ir          = ir_q;
  assign instr_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule
